// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch
// Description : Instruction prefetch queue between the MMU instruction port
//               and the controlpath, with segv halt and redirect restart.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic [31:0] mmu_instr,
    input  logic        mmu_wait,
    input  logic        mmu_segv,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        instr_fault,
    input  logic        pc_inc
);

    localparam int                 C_PTR_W = $clog2(DEPTH);
    localparam logic [C_PTR_W:0]   C_DEPTH = (C_PTR_W + 1)'(DEPTH);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [31:0]        r_mem_word [DEPTH];
    logic [31:0]        r_mem_pc   [DEPTH];
    logic [DEPTH-1:0]   r_mem_fault;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W:0]   r_count;
    logic [0:0]         r_state;
    logic [31:0]        r_fetch_addr;

    logic w_not_empty;
    logic w_accept;
    logic w_deq;

    assign w_not_empty = (r_count != '0);
    assign fetch_req   = (r_state == S_RUN) && (r_count < C_DEPTH) && !redirect;
    assign w_accept    = fetch_req && !mmu_wait;
    assign w_deq       = pc_inc && w_not_empty && !redirect;

    assign fetch_addr  = r_fetch_addr;
    assign instr_valid = w_not_empty;
    assign instruction = w_not_empty ? r_mem_word[r_rd_ptr]  : 32'h0;
    assign instr_pc    = w_not_empty ? r_mem_pc[r_rd_ptr]    : 32'h0;
    assign instr_fault = w_not_empty ? r_mem_fault[r_rd_ptr] : 1'b0;

    // Storage is not reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem_word[r_wr_ptr]  <= mmu_segv ? 32'h0 : mmu_instr;
            r_mem_pc[r_wr_ptr]    <= r_fetch_addr;
            r_mem_fault[r_wr_ptr] <= mmu_segv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_RUN;
            r_fetch_addr <= RESET_PC;
        end else if (redirect) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_RUN;
            r_fetch_addr <= {redirect_pc[31:2], 2'b00};
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                // A faulting fetch freezes the address until a redirect.
                if (mmu_segv) begin
                    r_state <= S_HALT;
                end else begin
                    r_fetch_addr <= r_fetch_addr + 32'd4;
                end
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch
// Description : Directed and randomized bench for instr_prefetch against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

    localparam int          C_DEPTH    = 4;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_PAT      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] fetch_addr;
    logic        fetch_req;
    logic [31:0] mmu_instr = 32'h0;
    logic        mmu_wait = 1'b1;
    logic        mmu_segv = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;
    logic        pc_inc = 1'b0;

    int checks = 0;
    int errors = 0;

    instr_prefetch #(.DEPTH(C_DEPTH), .RESET_PC(C_RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_addr(fetch_addr), .fetch_req(fetch_req), .mmu_instr(mmu_instr),
        .mmu_wait(mmu_wait), .mmu_segv(mmu_segv), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_fault(instr_fault),
        .pc_inc(pc_inc)
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO of delivered entries plus the next fetch address.
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr = C_RESET_PC;
    bit          m_halt = 1'b0;

    function automatic bit m_req();
        return !m_halt && (q.size() < C_DEPTH) && !redirect;
    endfunction

    task automatic model_step();
        bit   acc;
        bit   deq;
        ent_t e;
        if (rst) begin
            q.delete(); m_addr = C_RESET_PC; m_halt = 1'b0;
        end else if (redirect) begin
            q.delete(); m_addr = redirect_pc & ~32'h3; m_halt = 1'b0;
        end else begin
            acc = m_req() && !mmu_wait;
            deq = pc_inc && (q.size() != 0);
            if (deq) void'(q.pop_front());
            if (acc) begin
                e.word  = mmu_segv ? 32'h0 : mmu_instr;
                e.pc    = m_addr;
                e.fault = mmu_segv;
                q.push_back(e);
                if (mmu_segv) m_halt = 1'b1;
                else          m_addr = m_addr + 32'd4;
            end
        end
    endtask

    task automatic tick();
        mmu_instr = m_addr ^ C_PAT;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; pc_inc = 1'b0; mmu_wait = 1'b1; mmu_segv = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mmu_wait = 1'b0; pc_inc = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick(); tick();
        rst = 1'b0; redirect = 1'b0; pc_inc = 1'b0; mmu_wait = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instruction); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", instr_pc); end
        checks++; if (instr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", instr_fault); end
        checks++; if (fetch_addr !== C_RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", fetch_addr, C_RESET_PC); end
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_req got %0b want 1", fetch_req); end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        do_reset();
        mmu_wait = 1'b0; pc_inc = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            pc = 32'(4 * i);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, instr_valid); end
            checks++; if (instr_pc !== pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, pc); end
            checks++; if (instruction !== (pc ^ C_PAT)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, instruction, pc ^ C_PAT); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mmu_wait = 1'b0; pc_inc = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL full_req got %0b want 0", fetch_req); end
        checks++; if (fetch_addr !== 32'd16) begin errors++; $display("FAIL full_addr got %h want 10", fetch_addr); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL full_head got %h want 0", instr_pc); end
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        #1;
        checks++; if (instr_pc !== 32'd4) begin errors++; $display("FAIL pop_head got %h want 4", instr_pc); end
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL pop_req got %0b want 1", fetch_req); end
        tick();
        checks++; if (fetch_addr !== 32'd20) begin errors++; $display("FAIL refill_addr got %h want 14", fetch_addr); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL refill_req got %0b want 0", fetch_req); end
    endtask

    task automatic test_stall();
        do_reset();
        mmu_wait = 1'b0; pc_inc = 1'b0;
        tick(); tick();
        mmu_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_addr !== 32'd8) begin errors++; $display("FAIL stall_addr[%0d] got %h want 8", i, fetch_addr); end
            checks++; if (fetch_req !== 1'b1 || instr_pc !== 32'd0) begin errors++; $display("FAIL stall_hold[%0d] got req %0b pc %h want req 1 pc 0", i, fetch_req, instr_pc); end
        end
        mmu_wait = 1'b0;
        tick();
        checks++; if (fetch_addr !== 32'd12) begin errors++; $display("FAIL release_addr got %h want c", fetch_addr); end
        mmu_wait = 1'b1; pc_inc = 1'b1;
        tick(); tick();
        pc_inc = 1'b0;
        #1;
        checks++; if (instr_pc !== 32'd8 || instruction !== (32'd8 ^ C_PAT)) begin errors++; $display("FAIL stall_entry got pc %h instr %h want pc 8 instr %h", instr_pc, instruction, 32'd8 ^ C_PAT); end
    endtask

    task automatic test_segv();
        do_reset();
        mmu_wait = 1'b0; pc_inc = 1'b0;
        tick(); tick(); tick();
        mmu_segv = 1'b1;
        tick();
        mmu_segv = 1'b0;
        #1;
        checks++; if (fetch_req !== 1'b0 || fetch_addr !== 32'd12) begin errors++; $display("FAIL segv_halt got req %0b addr %h want req 0 addr c", fetch_req, fetch_addr); end
        pc_inc = 1'b1;
        tick(); tick(); tick();
        pc_inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instruction !== 32'h0 || instr_pc !== 32'd12)
                begin errors++; $display("FAIL segv_head[%0d] got v%0b f%0b i%h pc%h want v1 f1 i0 pc c", i, instr_valid, instr_fault, instruction, instr_pc); end
            checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL segv_req[%0d] got %0b want 0", i, fetch_req); end
        end
        redirect = 1'b1; redirect_pc = 32'h103;
        #1;
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL redir_req got %0b want 0", fetch_req); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fetch_addr !== 32'h100 || fetch_req !== 1'b1)
            begin errors++; $display("FAIL segv_redir got v%0b addr %h req %0b want v0 addr 100 req 1", instr_valid, fetch_addr, fetch_req); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        mmu_wait = 1'b0; pc_inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        redirect = 1'b1; pc_inc = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; pc_inc = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fetch_addr !== 32'h40) begin errors++; $display("FAIL redir_full got v%0b addr %h want v0 addr 40", instr_valid, fetch_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin errors++; $display("FAIL redir_first got v%0b pc %h want v1 pc 40", instr_valid, instr_pc); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0; mmu_wait = 1'b0; pc_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got %h want %h", i, instr_pc, exp_pc[i]); end
        end
        pc_inc = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mmu_wait = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || fetch_addr !== C_RESET_PC || fetch_req !== 1'b1)
            begin errors++; $display("FAIL midrst got v%0b addr %h req %0b want v0 addr %h req 1", instr_valid, fetch_addr, fetch_req, C_RESET_PC); end
    endtask

    task automatic test_random();
        ent_t h;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
            mmu_wait    = ($urandom_range(0, 3) == 0);
            mmu_segv    = ($urandom_range(0, 29) == 0);
            pc_inc      = ($urandom_range(0, 2) != 0);
            #1;
            if (q.size() != 0) h = q[0];
            else begin h.word = 32'h0; h.pc = 32'h0; h.fault = 1'b0; end
            checks++; if (fetch_req !== m_req()) begin errors++; $display("FAIL rnd_req[%0d] got %0b want %0b", i, fetch_req, m_req()); end
            checks++; if (fetch_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, fetch_addr, m_addr); end
            checks++; if (instr_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, instr_valid, q.size() != 0); end
            checks++; if (instruction !== h.word || instr_pc !== h.pc || instr_fault !== h.fault)
                begin errors++; $display("FAIL rnd_head[%0d] got %h/%h/%0b want %h/%h/%0b", i, instruction, instr_pc, instr_fault, h.word, h.pc, h.fault); end
            tick();
        end
        rst = 1'b0; redirect = 1'b0; mmu_segv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_segv();
        test_redirect_full();
        test_wrap_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
